// File: rtl/lieat_idu_disp_q_if.sv
// Decode-to-dispatch handshake bundle for lieat_idu_disp_q.
// The queue connects through the slave modport; the decode/execute side uses master.
interface lieat_idu_disp_q_if #(
   parameter int DEPTH = 2,
   parameter int NCH   = 3,
   parameter int DW    = 32,
   parameter int CHW   = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic           id_i_valid;
   logic           id_i_ready;
   logic [CHW-1:0] id_i_ch;
   logic [DW-1:0]  id_i_data;
   logic           disp_condition;
   logic           flush_req;
   logic [NCH-1:0] disp_valid;
   logic [NCH-1:0] disp_ready;
   logic [DW-1:0]  disp_data;
   logic [CHW-1:0] disp_ch;
   logic           longi_disp;
   logic           disp_err;
   logic [CW-1:0]  disp_cnt;
   logic           disp_empty;

   modport slave (
      input  id_i_valid, id_i_ch, id_i_data, disp_condition, flush_req, disp_ready,
      output id_i_ready, disp_valid, disp_data, disp_ch, longi_disp, disp_err,
             disp_cnt, disp_empty
   );

   modport master (
      output id_i_valid, id_i_ch, id_i_data, disp_condition, flush_req, disp_ready,
      input  id_i_ready, disp_valid, disp_data, disp_ch, longi_disp, disp_err,
             disp_cnt, disp_empty
   );
endinterface

// File: rtl/lieat_idu_disp_q.sv
// In-order dispatch queue: DEPTH-entry FIFO whose head is routed to one of NCH channels.
// Define LIEAT_DISP_BYPASS_EN to let an instruction arriving at an empty queue issue in the same cycle.
module lieat_idu_disp_q #(
   parameter int DEPTH = 2,
   parameter int NCH   = 3,
   parameter int DW    = 32,
   parameter int CHW   = 2
) (
   input  logic               clock,
   input  logic               reset,
   lieat_idu_disp_q_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if ((1 << CHW) < NCH) begin : g_bad_chw
         $error("lieat_idu_disp_q: CHW too narrow for NCH");
      end
      if (DEPTH < 1) begin : g_bad_depth
         $error("lieat_idu_disp_q: DEPTH must be at least 1");
      end
   endgenerate

   logic [DW-1:0]  data_mem_reg [DEPTH];
   logic [CHW-1:0] ch_mem_reg   [DEPTH];

   logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic           q_empty;
   logic [CHW-1:0] head_ch;
   logic [DW-1:0]  head_data;
   logic           bypass_act;
   logic [CHW-1:0] sel_ch;
   logic [DW-1:0]  sel_data;
   logic           head_vis;
   logic           head_ok;
   logic           ch_oor;
   logic [NCH-1:0] disp_valid_w;
   logic           hs;
   logic           err;
   logic           deq_evt;
   logic           deq;
   logic           enq;
   logic           ready_w;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   assign q_empty   = (cnt_reg == '0);
   assign head_ch   = ch_mem_reg[rd_ptr_reg];
   assign head_data = data_mem_reg[rd_ptr_reg];

`ifdef LIEAT_DISP_BYPASS_EN
   // Gated with reset so nothing is accepted through the bypass while held in reset.
   assign bypass_act = reset & q_empty & bus.id_i_valid & bus.disp_condition & ~bus.flush_req;
`else
   assign bypass_act = 1'b0;
`endif

   assign sel_ch   = bypass_act ? bus.id_i_ch   : head_ch;
   assign sel_data = bypass_act ? bus.id_i_data : head_data;
   assign head_vis = ~q_empty | bypass_act;
   assign head_ok  = head_vis & bus.disp_condition & ~bus.flush_req;

   // Widened by one bit so NCH == 2**CHW still compares correctly.
   assign ch_oor = ({1'b0, sel_ch} >= (CHW + 1)'(NCH));

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign disp_valid_w[gi] = head_ok & (sel_ch == CHW'(gi));
      end
   endgenerate

   assign hs      = |(disp_valid_w & bus.disp_ready);
   assign err     = head_ok & ch_oor;
   assign deq_evt = hs | err;

   // A bypassed instruction that issues never touches storage.
   assign deq     = deq_evt & ~bypass_act;
   assign ready_w = (cnt_reg < CW'(DEPTH)) | deq;
   assign enq     = bus.id_i_valid & ready_w & ~bus.flush_req & ~(bypass_act & deq_evt);

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      cnt_next    = cnt_reg;
      if (bus.flush_req) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         cnt_next    = '0;
      end else begin
         if (enq) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
         end
         if (deq) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
         end
         case ({enq, deq})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         cnt_reg    <= cnt_next;
      end
   end

   // Payload storage carries no reset; entries are only meaningful below cnt_reg.
   always_ff @(posedge clock) begin
      if (enq) begin
         data_mem_reg[wr_ptr_reg] <= bus.id_i_data;
         ch_mem_reg[wr_ptr_reg]   <= bus.id_i_ch;
      end
   end

   assign bus.id_i_ready = ready_w;
   assign bus.disp_valid = disp_valid_w;
   assign bus.disp_data  = sel_data;
   assign bus.disp_ch    = sel_ch;
   assign bus.longi_disp = hs;
   assign bus.disp_err   = err;
   assign bus.disp_cnt   = cnt_reg;
   assign bus.disp_empty = q_empty;
endmodule

// File: doc/lieat_idu_disp_q.md
Name: lieat_idu_disp_q

Overview:
- Parametrised dispatch stage between decode and the execution units.
- Buffers up to DEPTH decoded instructions in a FIFO and routes each head entry to one of NCH execution channels.
- A channel index carried with each instruction selects the channel, which is then handshaked in order.
- Supports flush and a dependency-stall gate, and reports occupancy.

Parameters:
DEPTH, 2, number of queue entries (>=1; non-power-of-two legal)
NCH, 3, number of execution channels (>=1)
DW, 32, payload width carried per entry
CHW, 2, channel-index width; must satisfy 2**CHW >= NCH

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
id_i_valid  input  1  decode offers an instruction
id_i_ready  output  1  queue accepts this cycle
id_i_ch  input  CHW  target channel index of the offered instruction
id_i_data  input  DW  payload of the offered instruction
disp_condition  input  1  head may issue (0 = hazard, e.g. OITF RAW dependency)
flush_req  input  1  synchronous flush of all queued entries
disp_valid  output  NCH  one-hot valid toward the channels
disp_ready  input  NCH  per-channel ready
disp_data  output  DW  head payload, shared by all channels
disp_ch  output  CHW  head channel index
longi_disp  output  1  pulse: head dispatched this cycle
disp_err  output  1  pulse: head carried an out-of-range channel and was retired
disp_cnt  output  clog2(DEPTH+1)  current occupancy
disp_empty  output  1  occupancy == 0

Behaviour:
- Storage: circular buffer with rd/wr pointers wrapping at DEPTH-1 -> 0, plus a count register. Pointers and count reset to 0 asynchronously while reset is low; payload storage is not reset.
- Reset values:
  - id_i_ready = 1, disp_valid = 0, longi_disp = 0, disp_err = 0.
  - disp_cnt = 0, disp_empty = 1.
  - disp_data and disp_ch are don't-care while empty.
- Enqueue: enq = id_i_valid & id_i_ready & ~flush_req. The entry is written at wr_ptr and becomes head-visible the next cycle, so minimum latency is 1 cycle.
- id_i_ready = (cnt < DEPTH) | deq. This allows a same-cycle enq+deq when full; cnt stays at DEPTH.
- Head issue:
  - head_ok = ~disp_empty & disp_condition & ~flush_req.
  - disp_valid[i] = head_ok & (head_ch == i).
  - With disp_condition = 0, disp_valid is all-zero and the head is held.
- Dequeue:
  - deq = |(disp_valid & disp_ready) | err.
  - longi_disp = |(disp_valid & disp_ready).
  - rd_ptr advances by one on deq. Strict in-order: there is no reordering across channels.
- Out-of-range channel (head_ch >= NCH, only possible when 2**CHW > NCH):
  - err = head_ok. disp_err pulses, the entry is retired without a handshake, and disp_valid stays 0.
- Count update: cnt_nxt = cnt + enq - deq. Simultaneous enq and deq leaves cnt unchanged. Enq is never blocked when cnt < DEPTH.
- Flush (priority over everything):
  - In the flush cycle: disp_valid = 0 combinationally, enq and deq are suppressed, and any id_i handshake is discarded.
  - Next cycle: cnt = 0, rd_ptr = wr_ptr = 0.
- Channel ready is sampled only for the selected channel; ready on other channels is ignored.
- Valid is not held sticky across disp_condition drops. A channel must tolerate valid falling without a handshake (hazard retraction).
- Asynchronous reset asserted mid-operation drops all entries immediately; no handshake completes in that cycle.

Optional Feature:
- Macro: LIEAT_DISP_BYPASS_EN
- Defined: when disp_empty & id_i_valid & disp_condition & ~flush_req, the incoming instruction drives disp_valid, disp_data and disp_ch combinationally in the same cycle.
  - If the selected channel accepts (or id_i_ch is out of range, giving a disp_err pulse), the instruction is not written and cnt stays 0.
  - Otherwise it is enqueued normally.
  - Zero-cycle latency.
- Undefined: no bypass; minimum enqueue-to-dispatch latency is 1 cycle.

Test Plan:
1. Reset low for 3 cycles, then release -> id_i_ready=1, disp_valid=0, disp_cnt=0, disp_empty=1.
2. DEPTH=2, all disp_ready=0: push ch=0/data=0xA, then ch=2/data=0xB -> disp_cnt=2, id_i_ready=0, disp_valid=3'b001, disp_data=0xA. Raise disp_ready[0] -> longi_disp=1; next cycle disp_valid=3'b100, disp_data=0xB.
3. Full queue; push ch=1 in the same cycle as the head dispatches -> id_i_ready=1, disp_cnt stays 2, order preserved (0xB then new entry).
4. Head ch=1 with disp_condition=0 for 4 cycles while disp_ready=3'b111 -> disp_valid=0, no longi_disp. Condition back to 1 -> dispatch in 1 cycle.
5. 2 entries queued; assert flush_req with id_i_valid=1 -> disp_valid=0 that cycle; next cycle disp_cnt=0, the flushed-cycle push is absent.
6. Push id_i_ch=3 with NCH=3 -> disp_err pulses one cycle, disp_valid stays 0, entry retired. Under LIEAT_DISP_BYPASS_EN: empty queue, push ch=0 with disp_ready[0]=1 -> longi_disp in the same cycle, disp_cnt stays 0.
